ahb_arbiter: RTL and testbench

Round-robin AHB bus arbiter that shares one AHB address/data bus between `NUM_MASTERS` instances of the team's AHB master interface. It issues one-hot grants and tracks the address-phase and data-phase owner so the bus mux selects the right master. Fixed-length bursts and locked sequences are never broken. It watches the shared `HTRANS`/`HBURST`/`HREADY`/`HRESP` to decide when handover is legal.

---
 rtl/ahb_arbiter.sv | 164 ++++++++++++++++
 tb/tb_ahb_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_arbiter
//   Round-robin arbiter sharing one AHB address/data bus between NUM_MASTERS
//   masters. It issues a one-hot grant and tracks the address-phase owner
//   (HMASTER) and the data-phase owner, which drives the write-data mux.
//   Fixed-length bursts and locked sequences are never broken. Handover is
//   judged from the shared HTRANS/HBURST/HREADY/HRESP.
//
// Ports
//   ahb_clk_in       in   1    bus clock, rising edge
//   ahb_rstn_in      in   1    asynchronous active-low reset
//   req_in           in   N    per-master bus request (HBUSREQ)
//   lock_in          in   N    per-master lock request (HLOCK)
//   ahb_trans_in     in   2    shared HTRANS (IDLE/BUSY/NONSEQ/SEQ)
//   ahb_burst_in     in   3    shared HBURST
//   ahb_ready_in     in   1    shared HREADY
//   ahb_resp_in      in   1    shared HRESP, 1 = ERROR
//   grant_out        out  N    one-hot grant (HGRANT)
//   master_out       out  MW   address-phase owner (HMASTER)
//   master_data_out  out  MW   data-phase owner
//   mastlock_out     out  1    current address phase is locked (HMASTLOCK)
// ---------------------------------------------------------------------------
module ahb_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int MW          = $clog2(NUM_MASTERS)
) (
  input  logic                   ahb_clk_in,
  input  logic                   ahb_rstn_in,
  input  logic [NUM_MASTERS-1:0] req_in,
  input  logic [NUM_MASTERS-1:0] lock_in,
  input  logic [1:0]             ahb_trans_in,
  input  logic [2:0]             ahb_burst_in,
  input  logic                   ahb_ready_in,
  input  logic                   ahb_resp_in,
  output logic [NUM_MASTERS-1:0] grant_out,
  output logic [MW-1:0]          master_out,
  output logic [MW-1:0]          master_data_out,
  output logic                   mastlock_out
);

  typedef enum logic [1:0] {
    ST_OPEN   = 2'd0,   // handover allowed
    ST_BURST  = 2'd1,   // fixed-length burst in progress
    ST_LOCKED = 2'd2    // locked sequence in progress
  } state_t;

  localparam logic [1:0] TR_IDLE   = 2'd0;
  localparam logic [1:0] TR_BUSY   = 2'd1;
  localparam logic [1:0] TR_NONSEQ = 2'd2;
  localparam logic [1:0] TR_SEQ    = 2'd3;

  state_t                 state, state_nxt;
  logic [3:0]             beat_cnt, cnt_nxt;
  logic [3:0]             burst_load;
  logic                   owner_lock;
  logic [MW-1:0]          cand;
  logic [MW-1:0]          arb_idx;
  logic                   arb_found;
  logic [NUM_MASTERS-1:0] arb_grant;
  logic [MW-1:0]          grant_idx;
  logic                   mastlock_nxt;

  // Remaining beats after the NONSEQ of a fixed-length burst.
  always_comb begin
    // NOTE: every signal written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    burst_load = 4'd0;
    case (ahb_burst_in)
      3'd2, 3'd3: burst_load = 4'd3;
      3'd4, 3'd5: burst_load = 4'd7;
      3'd6, 3'd7: burst_load = 4'd15;
      default:    burst_load = 4'd0;   // SINGLE and INCR never block handover
    endcase
  end

  assign owner_lock = lock_in[master_out];

  // Next state and beat counter.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = beat_cnt;
    if (ahb_resp_in && !ahb_ready_in) begin
      // First ERROR cycle aborts any burst or lock so the second cycle
      // can hand the bus over.
      state_nxt = ST_OPEN;
      cnt_nxt   = 4'd0;
    end else if (ahb_ready_in) begin
      case (ahb_trans_in)
        TR_NONSEQ: begin
          cnt_nxt = burst_load;
          if (state == ST_OPEN) begin
            if (owner_lock)              state_nxt = ST_LOCKED;
            else if (burst_load != 4'd0) state_nxt = ST_BURST;
          end
        end
        TR_SEQ: begin
          cnt_nxt = (beat_cnt == 4'd0) ? 4'd0 : beat_cnt - 4'd1;
          if (state == ST_BURST && cnt_nxt == 4'd0) state_nxt = ST_OPEN;
        end
        TR_IDLE: begin
          if (state == ST_LOCKED && !owner_lock) state_nxt = ST_OPEN;
        end
        TR_BUSY: ;   // BUSY holds the counter and state
        default: ;
      endcase
    end
  end

  // Round-robin search starting just after the address-phase owner.
  always_comb begin
    cand      = '0;
    arb_idx   = '0;
    arb_found = 1'b0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      cand = MW'((int'(master_out) + i) % NUM_MASTERS);
      if (!arb_found && req_in[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
    arb_grant = '0;
    // No requester: park the bus on the default master 0.
    arb_grant[arb_found ? arb_idx : '0] = 1'b1;
  end

  // Encode the current one-hot grant into the next owner index.
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      if (grant_out[i]) grant_idx = MW'(i);
  end

  // The incoming owner's lock is forwarded unless a plain fixed burst is in
  // progress; a handover edge counts as entering a lock for that owner.
  assign mastlock_nxt = lock_in[grant_idx] && (state_nxt != ST_BURST);

  always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
    if (!ahb_rstn_in) begin
      state    <= ST_OPEN;
      beat_cnt <= 4'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state    <= state_nxt;
      beat_cnt <= cnt_nxt;
    end
  end

  // Grant and ownership pipeline advance only on accepted cycles.
  always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
    if (!ahb_rstn_in) begin
      grant_out       <= NUM_MASTERS'(1);
      master_out      <= '0;
      master_data_out <= '0;
      mastlock_out    <= 1'b0;
    end else if (ahb_ready_in) begin
      master_data_out <= master_out;
      master_out      <= grant_idx;
      mastlock_out    <= mastlock_nxt;
      if (state_nxt == ST_OPEN) grant_out <= arb_grant;
    end
  end

endmodule

// File: tb/tb_ahb_arbiter.sv
module tb_ahb_arbiter;

  localparam int N  = 4;
  localparam int MW = 2;

  localparam logic [1:0] T_IDLE   = 2'd0;
  localparam logic [1:0] T_NONSEQ = 2'd2;
  localparam logic [1:0] T_SEQ    = 2'd3;
  localparam logic [2:0] B_SINGLE = 3'd0;
  localparam logic [2:0] B_INCR4  = 3'd3;
  localparam logic [2:0] B_INCR8  = 3'd5;
  localparam logic [2:0] B_INCR16 = 3'd7;

  logic          ahb_clk_in = 1'b0;
  logic          ahb_rstn_in;
  logic [N-1:0]  req_in, lock_in;
  logic [1:0]    ahb_trans_in;
  logic [2:0]    ahb_burst_in;
  logic          ahb_ready_in, ahb_resp_in;
  logic [N-1:0]  grant_out;
  logic [MW-1:0] master_out, master_data_out;
  logic          mastlock_out;

  int checks = 0;
  int errors = 0;

  ahb_arbiter #(.NUM_MASTERS(N)) dut (
    .ahb_clk_in      (ahb_clk_in),
    .ahb_rstn_in     (ahb_rstn_in),
    .req_in          (req_in),
    .lock_in         (lock_in),
    .ahb_trans_in    (ahb_trans_in),
    .ahb_burst_in    (ahb_burst_in),
    .ahb_ready_in    (ahb_ready_in),
    .ahb_resp_in     (ahb_resp_in),
    .grant_out       (grant_out),
    .master_out      (master_out),
    .master_data_out (master_data_out),
    .mastlock_out    (mastlock_out)
  );

  always #5 ahb_clk_in = ~ahb_clk_in;

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge ahb_clk_in);
    #1;
  endtask

  task automatic bus(input logic [1:0] t, input logic [2:0] b,
                     input logic r, input logic e);
    ahb_trans_in = t;
    ahb_burst_in = b;
    ahb_ready_in = r;
    ahb_resp_in  = e;
  endtask

  task automatic do_reset();
    req_in  = '0;
    lock_in = '0;
    bus(T_IDLE, B_SINGLE, 1'b1, 1'b0);
    ahb_rstn_in = 1'b0;
    tick();
    ahb_rstn_in = 1'b1;
  endtask

  task automatic test_reset();
    req_in  = 4'b0110;
    lock_in = '0;
    bus(T_IDLE, B_SINGLE, 1'b1, 1'b0);
    ahb_rstn_in = 1'b0;
    tick();
    tick();
    checks++;
    if ({grant_out, master_out, master_data_out, mastlock_out} !== {4'b0001, 2'd0, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_held grant=%b master=%0d mdata=%0d lock=%b expected 0001/0/0/0",
               grant_out, master_out, master_data_out, mastlock_out);
    end
    ahb_rstn_in = 1'b1;
    req_in = '0;
    tick();
    checks++;
    if ({grant_out, master_out, mastlock_out} !== {4'b0001, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_release grant=%b master=%0d lock=%b expected 0001/0/0",
               grant_out, master_out, mastlock_out);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g  [10] = '{4'b0010, 4'b0010, 4'b1000, 4'b1000, 4'b0001,
                                4'b0001, 4'b0010, 4'b0010, 4'b1000, 4'b1000};
    logic [1:0] exp_m  [10] = '{2'd0, 2'd1, 2'd1, 2'd3, 2'd3, 2'd0, 2'd0, 2'd1, 2'd1, 2'd3};
    logic [1:0] exp_md [10] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd3, 2'd3, 2'd0, 2'd0, 2'd1, 2'd1};
    do_reset();
    req_in = 4'b1011;
    bus(T_NONSEQ, B_SINGLE, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({grant_out, master_out, master_data_out} !== {exp_g[i], exp_m[i], exp_md[i]}) begin
        errors++;
        $display("FAIL rr_edge%0d grant=%b master=%0d mdata=%0d expected %b/%0d/%0d",
                 i + 1, grant_out, master_out, master_data_out, exp_g[i], exp_m[i], exp_md[i]);
      end
    end
    req_in = '0;
    bus(T_IDLE, B_SINGLE, 1'b1, 1'b0);
    tick();
    checks++;
    if (grant_out !== 4'b0001) begin
      errors++;
      $display("FAIL rr_no_request grant=%b expected 0001", grant_out);
    end
  endtask

  task automatic test_incr8();
    do_reset();
    req_in = 4'b0100;
    tick();
    tick();
    checks++;
    if ({grant_out, master_out} !== {4'b0100, 2'd2}) begin
      errors++;
      $display("FAIL incr8_setup grant=%b master=%0d expected 0100/2", grant_out, master_out);
    end
    req_in = 4'b0101;
    bus(T_NONSEQ, B_INCR8, 1'b1, 1'b0);
    tick();
    for (int beat = 2; beat <= 8; beat++) begin
      checks++;
      if (grant_out !== 4'b0100) begin
        errors++;
        $display("FAIL incr8_hold_beat%0d grant=%b expected 0100", beat - 1, grant_out);
      end
      bus(T_SEQ, B_INCR8, 1'b1, 1'b0);
      tick();
    end
    checks++;
    if ({grant_out, master_out} !== {4'b0001, 2'd2}) begin
      errors++;
      $display("FAIL incr8_last_beat grant=%b master=%0d expected 0001/2", grant_out, master_out);
    end
    req_in = 4'b0001;
    bus(T_IDLE, B_SINGLE, 1'b1, 1'b0);
    tick();
    checks++;
    if ({grant_out, master_out, master_data_out} !== {4'b0001, 2'd0, 2'd2}) begin
      errors++;
      $display("FAIL incr8_handover grant=%b master=%0d mdata=%0d expected 0001/0/2",
               grant_out, master_out, master_data_out);
    end
  endtask

  task automatic test_wait_states();
    do_reset();
    req_in = 4'b0010;
    tick();
    tick();
    req_in = 4'b1010;
    bus(T_NONSEQ, B_INCR4, 1'b1, 1'b0);
    tick();
    for (int w = 0; w < 3; w++) begin
      req_in = 4'b1000;
      bus(T_SEQ, B_INCR4, 1'b0, 1'b0);
      tick();
      checks++;
      if ({grant_out, master_out, master_data_out, mastlock_out} !== {4'b0010, 2'd1, 2'd1, 1'b0}) begin
        errors++;
        $display("FAIL wait_freeze%0d grant=%b master=%0d mdata=%0d lock=%b expected 0010/1/1/0",
                 w, grant_out, master_out, master_data_out, mastlock_out);
      end
    end
    bus(T_SEQ, B_INCR4, 1'b1, 1'b0);
    tick();
    tick();
    checks++;
    if (grant_out !== 4'b0010) begin
      errors++;
      $display("FAIL wait_beat3 grant=%b expected 0010", grant_out);
    end
    tick();
    checks++;
    if ({grant_out, master_out} !== {4'b1000, 2'd1}) begin
      errors++;
      $display("FAIL wait_beat4 grant=%b master=%0d expected 1000/1", grant_out, master_out);
    end
    bus(T_IDLE, B_SINGLE, 1'b1, 1'b0);
    tick();
    checks++;
    if (master_out !== 2'd3) begin
      errors++;
      $display("FAIL wait_handover master=%0d expected 3", master_out);
    end
  endtask

  task automatic test_locked();
    do_reset();
    req_in  = 4'b0010;
    lock_in = 4'b0010;
    tick();
    checks++;
    if ({grant_out, mastlock_out} !== {4'b0010, 1'b0}) begin
      errors++;
      $display("FAIL lock_grant grant=%b lock=%b expected 0010/0", grant_out, mastlock_out);
    end
    tick();
    checks++;
    if ({grant_out, master_out, mastlock_out} !== {4'b0010, 2'd1, 1'b1}) begin
      errors++;
      $display("FAIL lock_own grant=%b master=%0d lock=%b expected 0010/1/1",
               grant_out, master_out, mastlock_out);
    end
    req_in = 4'b1010;
    bus(T_NONSEQ, B_SINGLE, 1'b1, 1'b0);
    for (int s = 0; s < 2; s++) begin
      tick();
      checks++;
      if ({grant_out, master_out, mastlock_out} !== {4'b0010, 2'd1, 1'b1}) begin
        errors++;
        $display("FAIL lock_single%0d grant=%b master=%0d lock=%b expected 0010/1/1",
                 s, grant_out, master_out, mastlock_out);
      end
    end
    lock_in = '0;
    bus(T_IDLE, B_SINGLE, 1'b1, 1'b0);
    tick();
    checks++;
    if ({grant_out, master_out, mastlock_out} !== {4'b1000, 2'd1, 1'b0}) begin
      errors++;
      $display("FAIL lock_release grant=%b master=%0d lock=%b expected 1000/1/0",
               grant_out, master_out, mastlock_out);
    end
    req_in = 4'b1000;
    tick();
    checks++;
    if ({master_out, mastlock_out} !== {2'd3, 1'b0}) begin
      errors++;
      $display("FAIL lock_handover master=%0d lock=%b expected 3/0", master_out, mastlock_out);
    end
  endtask

  task automatic test_error();
    do_reset();
    req_in = 4'b0100;
    tick();
    tick();
    req_in = 4'b0101;
    bus(T_NONSEQ, B_INCR16, 1'b1, 1'b0);
    tick();
    bus(T_SEQ, B_INCR16, 1'b1, 1'b0);
    for (int beat = 2; beat <= 5; beat++) tick();
    checks++;
    if (grant_out !== 4'b0100) begin
      errors++;
      $display("FAIL err_before grant=%b expected 0100", grant_out);
    end
    bus(T_SEQ, B_INCR16, 1'b0, 1'b1);
    tick();
    checks++;
    if ({grant_out, master_out} !== {4'b0100, 2'd2}) begin
      errors++;
      $display("FAIL err_cycle1 grant=%b master=%0d expected 0100/2", grant_out, master_out);
    end
    bus(T_IDLE, B_SINGLE, 1'b1, 1'b1);
    tick();
    checks++;
    if (grant_out !== 4'b0001) begin
      errors++;
      $display("FAIL err_cycle2 grant=%b expected 0001", grant_out);
    end
    bus(T_IDLE, B_SINGLE, 1'b1, 1'b0);
    tick();
    checks++;
    if (master_out !== 2'd0) begin
      errors++;
      $display("FAIL err_handover master=%0d expected 0", master_out);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req_in = 4'b0100;
    tick();
    tick();
    bus(T_NONSEQ, B_INCR4, 1'b1, 1'b0);
    tick();
    bus(T_SEQ, B_INCR4, 1'b1, 1'b0);
    tick();
    #2;
    ahb_rstn_in = 1'b0;
    #1;
    checks++;
    if ({grant_out, master_out, master_data_out, mastlock_out} !== {4'b0001, 2'd0, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL midburst_async grant=%b master=%0d mdata=%0d lock=%b expected 0001/0/0/0",
               grant_out, master_out, master_data_out, mastlock_out);
    end
    req_in = '0;
    bus(T_IDLE, B_SINGLE, 1'b1, 1'b0);
    tick();
    ahb_rstn_in = 1'b1;
    req_in = 4'b1000;
    tick();
    checks++;
    if (grant_out !== 4'b1000) begin
      errors++;
      $display("FAIL midburst_open grant=%b expected 1000", grant_out);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_round_robin();
    test_incr8();
    test_wait_states();
    test_locked();
    test_error();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
